// File: rtl/xc2_toggle_sched.sv
// Round-robin scheduler granting one requester at a time a burst of toggles on a shared T flip-flop.
// Optional build macro XC2_TOGGLE_SCHED_ABORT_EN: dropping req of the winner mid-burst ends it early.
module xc2_toggle_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  t_en,
  output logic                  o
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] win, win_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             o_nxt;
  logic [NREQ-1:0]  gnt_nxt, done_nxt;
  logic             busy_nxt, t_en_nxt;

  logic [PTR_W-1:0] pick, idx;
  logic             pick_vld;
  logic [CNT_W-1:0] pick_len;
  logic             abort;

  // First pending request searching upward from ptr with wrap
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NREQ);
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pick_len = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (PTR_W'(j) == pick) pick_len = len[j*CNT_W +: CNT_W];
    end
  end

`ifdef XC2_TOGGLE_SCHED_ABORT_EN
  assign abort = ~req[win];
`else
  assign abort = 1'b0;
`endif

  // Next state plus output decode of the next state, so registered outputs track the state register
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    win_nxt   = win;
    cnt_nxt   = cnt;
    o_nxt     = o;

    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          win_nxt   = pick;
          cnt_nxt   = pick_len;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (abort || (cnt == '0)) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          o_nxt   = ~o;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ptr_nxt   = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    t_en_nxt = (state_nxt == S_RUN);
    gnt_nxt  = busy_nxt ? (NREQ'(1) << win_nxt) : '0;
    done_nxt = (state_nxt == S_DONE) ? (NREQ'(1) << win_nxt) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      win   <= '0;
      cnt   <= '0;
      o     <= 1'b0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      t_en  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      win   <= win_nxt;
      cnt   <= cnt_nxt;
      o     <= o_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
      t_en  <= t_en_nxt;
    end
  end

endmodule

// File: tb/tb_xc2_toggle_sched.sv
// Directed bench for xc2_toggle_sched: latency, burst length, round-robin order, zero-length, async reset, abort.
module tb_xc2_toggle_sched;

  logic        clk;
  logic        rst_n = 1'b1;
  logic [3:0]  req;
  logic [31:0] len;
  logic [3:0]  gnt, done;
  logic        busy, t_en, o;

  int   n_chk, n_pass;
  int   tog_acc, ten_acc;
  logic o_prev;

  xc2_toggle_sched #(.NREQ(4), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .t_en (t_en),
    .o    (o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  // Advance one cycle and sample 1 time unit after the edge, accumulating toggle/enable counts
  task automatic tick();
    @(posedge clk);
    #1;
    if (o !== o_prev) tog_acc++;
    if (t_en === 1'b1) ten_acc++;
    o_prev = o;
  endtask

  task automatic clear_acc();
    tog_acc = 0;
    ten_acc = 0;
    o_prev  = o;
  endtask

  task automatic set_len(input int i, input logic [7:0] v);
    len[i*8 +: 8] = v;
  endtask

  task automatic wait_grant(input int max, output int cyc);
    cyc = 0;
    while (gnt === 4'b0000 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_to_done(input int max, output int cyc);
    cyc = 0;
    while (done === 4'b0000 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_acc();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_chk++; if ({gnt, done, busy, t_en, o} !== 11'b0) $display("FAIL reset_async: got %b want 0", {gnt, done, busy, t_en, o}); else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_acc();
    tick();
    n_chk++; if ({gnt, done, busy, t_en, o} !== 11'b0) $display("FAIL reset_idle: got %b want 0", {gnt, done, busy, t_en, o}); else n_pass++;
  endtask

  task automatic test_single();
    int c;
    set_len(0, 8'd5);
    req = 4'b0001;
    clear_acc();
    tick();
    n_chk++; if (gnt !== 4'b0001) $display("FAIL single_gnt_latency: got %b want 0001", gnt); else n_pass++;
    n_chk++; if (busy !== 1'b1 || t_en !== 1'b0) $display("FAIL single_grant_state: busy %b t_en %b want 1 0", busy, t_en); else n_pass++;
    run_to_done(20, c);
    n_chk++; if (c !== 6) $display("FAIL single_done_cycle: got %0d want 6", c); else n_pass++;
    n_chk++; if (ten_acc !== 5) $display("FAIL single_ten_count: got %0d want 5", ten_acc); else n_pass++;
    n_chk++; if (tog_acc !== 5) $display("FAIL single_toggles: got %0d want 5", tog_acc); else n_pass++;
    n_chk++; if (o !== 1'b1) $display("FAIL single_o_final: got %b want 1", o); else n_pass++;
    n_chk++; if (done !== 4'b0001 || gnt !== 4'b0001 || t_en !== 1'b0) $display("FAIL single_done_state: done %b gnt %b t_en %b", done, gnt, t_en); else n_pass++;
    req = 4'b0000;
    tick();
    n_chk++; if ({gnt, done, busy} !== 9'b0 || o !== 1'b1) $display("FAIL single_idle_after: gnt %b done %b busy %b o %b", gnt, done, busy, o); else n_pass++;
  endtask

  task automatic test_round_robin();
    int c;
    logic [3:0] exp_g;
    logic o_start;
    do_reset();
    for (int i = 0; i < 4; i++) set_len(i, 8'd2);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1) << (k % 4);
      wait_grant(4, c);
      n_chk++; if (gnt !== exp_g) $display("FAIL rr_order_%0d: got %b want %b", k, gnt, exp_g); else n_pass++;
      n_chk++; if (c !== 1) $display("FAIL rr_gap_%0d: grant after %0d cycles want 1", k, c); else n_pass++;
      o_start = o;
      clear_acc();
      run_to_done(10, c);
      n_chk++; if (tog_acc !== 2 || o !== o_start) $display("FAIL rr_burst_%0d: toggles %0d o %b want 2 %b", k, tog_acc, o, o_start); else n_pass++;
      n_chk++; if (done !== exp_g) $display("FAIL rr_done_%0d: got %b want %b", k, done, exp_g); else n_pass++;
      if (k == 4) req = 4'b0000;
      tick();
      n_chk++; if (busy !== 1'b0 || gnt !== 4'b0000) $display("FAIL rr_idle_%0d: busy %b gnt %b want 0", k, busy, gnt); else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    logic o_start;
    set_len(1, 8'd0);
    req = 4'b0010;
    o_start = o;
    clear_acc();
    tick();
    n_chk++; if (gnt !== 4'b0010 || t_en !== 1'b0) $display("FAIL zero_grant: gnt %b t_en %b want 0010 0", gnt, t_en); else n_pass++;
    tick();
    n_chk++; if (done !== 4'b0010 || gnt !== 4'b0010 || t_en !== 1'b0) $display("FAIL zero_done: done %b gnt %b t_en %b", done, gnt, t_en); else n_pass++;
    n_chk++; if (o !== o_start) $display("FAIL zero_o: got %b want %b", o, o_start); else n_pass++;
    req = 4'b0000;
    tick();
    n_chk++; if (busy !== 1'b0 || done !== 4'b0000 || ten_acc !== 0) $display("FAIL zero_after: busy %b done %b t_en cycles %0d", busy, done, ten_acc); else n_pass++;
  endtask

  task automatic test_reset_midburst();
    int c;
    do_reset();
    set_len(2, 8'd255);
    req = 4'b0100;
    wait_grant(4, c);
    n_chk++; if (gnt !== 4'b0100) $display("FAIL long_grant: got %b want 0100", gnt); else n_pass++;
    repeat (100) tick();
    n_chk++; if (t_en !== 1'b1 || o !== 1'b1) $display("FAIL long_run100: t_en %b o %b want 1 1", t_en, o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({gnt, done, busy, t_en, o} !== 11'b0) $display("FAIL reset_midburst: got %b want 0", {gnt, done, busy, t_en, o}); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_acc();
    wait_grant(4, c);
    n_chk++; if (gnt !== 4'b0100 || c !== 1) $display("FAIL restart_grant: gnt %b after %0d want 0100 after 1", gnt, c); else n_pass++;
    run_to_done(300, c);
    n_chk++; if (c !== 256 || done !== 4'b0100) $display("FAIL restart_done: done %b after %0d want 0100 after 256", done, c); else n_pass++;
    n_chk++; if (tog_acc !== 255 || ten_acc !== 255 || o !== 1'b1) $display("FAIL restart_burst: toggles %0d t_en %0d o %b want 255 255 1", tog_acc, ten_acc, o); else n_pass++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_fairness();
    int c;
    set_len(3, 8'd1);
    set_len(0, 8'd1);
    req = 4'b1000;
    wait_grant(4, c);
    n_chk++; if (gnt !== 4'b1000) $display("FAIL fair_first: got %b want 1000", gnt); else n_pass++;
    run_to_done(5, c);
    req = 4'b0000;
    tick();
    req = 4'b1001;
    wait_grant(4, c);
    n_chk++; if (gnt !== 4'b0001) $display("FAIL fair_wrap: got %b want 0001", gnt); else n_pass++;
    run_to_done(5, c);
    tick();
    wait_grant(4, c);
    n_chk++; if (gnt !== 4'b1000 || c !== 1) $display("FAIL fair_b2b: gnt %b after %0d want 1000 after 1", gnt, c); else n_pass++;
    run_to_done(5, c);
    n_chk++; if (done !== 4'b1000) $display("FAIL fair_done: got %b want 1000", done); else n_pass++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    int c;
    int exp_tog, exp_ten;
    logic o_start;
`ifdef XC2_TOGGLE_SCHED_ABORT_EN
    exp_tog = 4;
    exp_ten = 5;
`else
    exp_tog = 10;
    exp_ten = 10;
`endif
    set_len(0, 8'd10);
    req = 4'b0001;
    wait_grant(4, c);
    n_chk++; if (gnt !== 4'b0001) $display("FAIL abort_grant: got %b want 0001", gnt); else n_pass++;
    o_start = o;
    clear_acc();
    repeat (5) tick();
    req = 4'b0000;
    run_to_done(20, c);
    n_chk++; if (done !== 4'b0001) $display("FAIL abort_done: got %b want 0001", done); else n_pass++;
    n_chk++; if (tog_acc !== exp_tog || ten_acc !== exp_ten) $display("FAIL abort_count: toggles %0d t_en %0d want %0d %0d", tog_acc, ten_acc, exp_tog, exp_ten); else n_pass++;
    n_chk++; if (o !== o_start) $display("FAIL abort_o: got %b want %b", o, o_start); else n_pass++;
    tick();
    n_chk++; if (busy !== 1'b0 || done !== 4'b0000) $display("FAIL abort_idle: busy %b done %b want 0", busy, done); else n_pass++;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    tog_acc = 0;
    ten_acc = 0;
    o_prev  = 1'b0;
    req     = 4'b0000;
    len     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_reset_midburst();
    test_fairness();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
